// File: rtl/mul_div_unit_if.sv
// Request/response bundle between a pipeline and the HI/LO multiply-divide unit.
interface mul_div_unit_if;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [2:0]  md_op;
  logic        md_start;
  logic        md_flush;
  logic        md_busy;
  logic        md_done;
  logic        md_div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_a, md_b, md_op, md_start, md_flush,
    input  md_busy, md_done, md_div_zero, hi, lo
  );

  modport slave (
    input  md_a, md_b, md_op, md_start, md_flush,
    output md_busy, md_done, md_div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU plus MTHI/MTLO with architectural HI/LO.
// Optional MD_FAST_MUL_EN: single-cycle multiplier, division stays 32 cycles.
module mul_div_unit (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  md
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      abs32 = 32'd0 - v;
    end else begin
      abs32 = v;
    end
  endfunction

  function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic n);
    if (n) begin
      neg32_if = 32'd0 - v;
    end else begin
      neg32_if = v;
    end
  endfunction

  logic [1:0]  state_r, state_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [63:0] work_r, work_nxt_s;
  logic [31:0] a_r, a_nxt_s;
  logic [31:0] b_r, b_nxt_s;
  logic        is_div_r, is_div_nxt_s;
  logic        neg_q_r, neg_q_nxt_s;
  logic        neg_r_r, neg_r_nxt_s;
  logic        div_zero_r, div_zero_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic        dz_r, dz_nxt_s;

  logic        sgn_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_trial_s;
  logic [63:0] div_next_s;
  logic [63:0] work_step_s;
  logic [63:0] mul_mag_s;
  logic [63:0] mul_res_s;
  logic [31:0] quo_res_s;
  logic [31:0] rem_res_s;
  logic        last_s;

  // Operands are latched as magnitudes; signs are re-applied on the write edge.
  assign sgn_s   = ~md.md_op[0];
  assign abs_a_s = abs32(md.md_a, sgn_s);
  assign abs_b_s = abs32(md.md_b, sgn_s);

  // Multiply: shift-add with the multiplier in the low half of work_r.
  assign mul_sum_s  = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, a_r} : 33'd0);
  assign mul_next_s = {mul_sum_s, work_r[31:1]};

  // Restoring divide: remainder in the high half, quotient bits shift in at bit 0.
  assign div_trial_s = work_r[63:31] - {1'b0, b_r};
  assign div_next_s  = div_trial_s[32] ? {work_r[62:0], 1'b0}
                                       : {div_trial_s[31:0], work_r[30:0], 1'b1};

  assign work_step_s = is_div_r ? div_next_s : mul_next_s;

`ifdef MD_FAST_MUL_EN
  assign last_s    = (~is_div_r) | (cnt_r == 5'd31);
  assign mul_mag_s = {32'd0, a_r} * {32'd0, b_r};
`else
  assign last_s    = (cnt_r == 5'd31);
  assign mul_mag_s = work_step_s;
`endif

  assign mul_res_s = neg_q_r ? (64'd0 - mul_mag_s) : mul_mag_s;
  assign quo_res_s = neg32_if(work_step_s[31:0], neg_q_r);
  assign rem_res_s = neg32_if(work_step_s[63:32], neg_r_r);

  // Next-state, datapath and HI/LO update; flush overrides everything but reset.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    work_nxt_s     = work_r;
    a_nxt_s        = a_r;
    b_nxt_s        = b_r;
    is_div_nxt_s   = is_div_r;
    neg_q_nxt_s    = neg_q_r;
    neg_r_nxt_s    = neg_r_r;
    div_zero_nxt_s = div_zero_r;
    hi_nxt_s       = hi_r;
    lo_nxt_s       = lo_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    dz_nxt_s       = 1'b0;

    if (md.md_flush) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 5'd0;
      busy_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          work_nxt_s = work_step_s;
          cnt_nxt_s  = cnt_r + 5'd1;
          if (last_s) begin
            state_nxt_s = ST_DONE;
            cnt_nxt_s   = 5'd0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            dz_nxt_s    = div_zero_r;
            if (!is_div_r) begin
              hi_nxt_s = mul_res_s[63:32];
              lo_nxt_s = mul_res_s[31:0];
            end else if (!div_zero_r) begin
              hi_nxt_s = rem_res_s;
              lo_nxt_s = quo_res_s;
            end else begin
              hi_nxt_s = hi_r;
              lo_nxt_s = lo_r;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_nxt_s = ST_IDLE;
          if (md.md_start) begin
            case (md.md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_nxt_s    = ST_RUN;
                cnt_nxt_s      = 5'd0;
                busy_nxt_s     = 1'b1;
                a_nxt_s        = abs_a_s;
                b_nxt_s        = abs_b_s;
                is_div_nxt_s   = md.md_op[1];
                neg_q_nxt_s    = sgn_s & (md.md_a[31] ^ md.md_b[31]);
                neg_r_nxt_s    = sgn_s & md.md_a[31];
                div_zero_nxt_s = md.md_op[1] & (md.md_b == 32'd0);
                work_nxt_s     = {32'd0, (md.md_op[1] ? abs_a_s : abs_b_s)};
              end
              OP_MTHI: hi_nxt_s = md.md_a;
              OP_MTLO: lo_nxt_s = md.md_a;
              default: state_nxt_s = ST_IDLE;
            endcase
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      work_r     <= 64'd0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dz_r       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      work_r     <= work_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      is_div_r   <= is_div_nxt_s;
      neg_q_r    <= neg_q_nxt_s;
      neg_r_r    <= neg_r_nxt_s;
      div_zero_r <= div_zero_nxt_s;
      hi_r       <= hi_nxt_s;
      lo_r       <= lo_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      dz_r       <= dz_nxt_s;
    end
  end

  assign md.md_busy     = busy_r;
  assign md.md_done     = done_r;
  assign md.md_div_zero = dz_r;
  assign md.hi          = hi_r;
  assign md.lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: reference arithmetic model, latency and control checks.
module tb_mul_div_unit;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic clk;
  logic reset;
  mul_div_unit_if md_if ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference model returns {div_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    logic [63:0]        p;
    logic signed [31:0] sa, sb, q, r;
    model = {1'b0, cur_hi, cur_lo};
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = {1'b0, p}; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; model = {1'b0, p}; end
      3'd2: begin
        if (b == 32'd0) model = {1'b1, cur_hi, cur_lo};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {1'b0, 32'd0, 32'h8000_0000};
        else begin q = sa / sb; r = sa % sb; model = {1'b0, r, q}; end
      end
      3'd3: begin
        if (b == 32'd0) model = {1'b1, cur_hi, cur_lo};
        else model = {1'b0, a % b, a / b};
      end
      default: model = {1'b0, cur_hi, cur_lo};
    endcase
  endfunction

  task automatic drive_idle();
    md_if.md_a = 32'd0; md_if.md_b = 32'd0; md_if.md_op = 3'd7;
    md_if.md_start = 1'b0; md_if.md_flush = 1'b0;
  endtask

  // Issue one iterative op, push expectation, wait (bounded) for md_done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] opa, input logic [31:0] opb, input bit in_place,
                        output int cyc, output logic [31:0] ohi, output logic [31:0] olo,
                        output logic odz, output logic busy1);
    exp_t        e;
    logic [64:0] m;
    if (!in_place) @(negedge clk);
    md_if.md_op = op; md_if.md_a = opa; md_if.md_b = opb; md_if.md_start = 1'b1;
    m = model(op, opa, opb, hi_m, lo_m);
    e.dz = m[64]; e.hi = m[63:32]; e.lo = m[31:0];
    e.lat = (op[1] ? DIV_LAT : MUL_LAT) + 1;
    hi_m = m[63:32]; lo_m = m[31:0];
    sb_q.push_back(e);
    cyc = -1; ohi = 32'd0; olo = 32'd0; odz = 1'b0; busy1 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin md_if.md_start = 1'b0; busy1 = md_if.md_busy; end
      if (md_if.md_done) begin
        cyc = c; ohi = md_if.hi; olo = md_if.lo; odz = md_if.md_div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, md_if.md_div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero",
               md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, md_if.md_div_zero);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({md_if.md_busy, md_if.md_done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", md_if.md_busy, md_if.md_done);
    end
  endtask

  task automatic test_multiply();
    logic [2:0]  ops[8]  = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [31:0] as[8]   = '{32'hFFFF_FFFF, 32'd3, 32'h1234_5678, 32'hFFFF_FFFE, 32'h8000_0000,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'd0};
    logic [31:0] bs[8]   = '{32'hFFFF_FFFF, 32'd5, 32'h9ABC_DEF0, 32'd3, 32'h8000_0000,
                             32'hFFFF_FFF7, 32'd1, 32'hDEAD_BEEF};
    int cyc; logic [31:0] ohi, olo; logic odz, b1; exp_t e;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, cyc, ohi, olo, odz, b1);
      e = sb_q.pop_front();
      checks++;
      if ({ohi, olo, odz} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("FAIL mul_result[%0d]: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                 i, ohi, olo, odz, e.hi, e.lo, e.dz);
      end
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d, expected %0d", i, cyc, e.lat);
      end
      checks++;
      if (b1 !== 1'b1) begin
        errors++;
        $display("FAIL mul_busy[%0d]: got %b, expected 1", i, b1);
      end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  ops[7] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] as[7]  = '{32'hFFFF_FFF9, 32'd100, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'hFFFF_FF9C};
    logic [31:0] bs[7]  = '{32'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'hFFFF_FFF9};
    int cyc; logic [31:0] ohi, olo; logic odz, b1; exp_t e;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, cyc, ohi, olo, odz, b1);
      e = sb_q.pop_front();
      checks++;
      if ({ohi, olo, odz} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("FAIL div_result[%0d]: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                 i, ohi, olo, odz, e.hi, e.lo, e.dz);
      end
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d, expected %0d", i, cyc, e.lat);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc; logic [31:0] ohi, olo; logic odz, b1; exp_t e;
    @(negedge clk);
    md_if.md_op = 3'd4; md_if.md_a = 32'h11; md_if.md_start = 1'b1;
    @(negedge clk);
    md_if.md_op = 3'd5; md_if.md_a = 32'h22;
    @(negedge clk);
    md_if.md_start = 1'b0;
    hi_m = 32'h11; lo_m = 32'h22;
    run_op(3'd3, 32'd100, 32'd0, 1'b0, cyc, ohi, olo, odz, b1);
    e = sb_q.pop_front();
    checks++;
    if ({ohi, olo, odz} !== {e.hi, e.lo, e.dz} || e.dz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: got hi=%h lo=%h dz=%b, expected hi=00000011 lo=00000022 dz=1", ohi, olo, odz);
    end
    checks++;
    if (cyc !== DIV_LAT + 1) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d, expected %0d", cyc, DIV_LAT + 1);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    md_if.md_op = 3'd3; md_if.md_a = 32'd100; md_if.md_b = 32'd7; md_if.md_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      md_if.md_start = 1'b0;
      if (c == 5) begin md_if.md_op = 3'd1; md_if.md_a = 32'd3; md_if.md_b = 32'd5; md_if.md_start = 1'b1; end
      if (c == 10) begin
        checks++;
        if (md_if.md_busy !== 1'b1) begin
          errors++;
          $display("FAIL flush_busy_before: got %b, expected 1", md_if.md_busy);
        end
        md_if.md_flush = 1'b1;
      end
    end
    @(negedge clk);
    md_if.md_flush = 1'b0;
    checks++;
    if (md_if.md_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_after: got %b, expected 0", md_if.md_busy);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_if.md_done || md_if.md_busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_done: got activity=%b, expected 0", seen);
    end
    checks++;
    if ({md_if.hi, md_if.lo} !== {hi_m, lo_m}) begin
      errors++;
      $display("FAIL flush_hilo: got hi=%h lo=%h, expected hi=%h lo=%h", md_if.hi, md_if.lo, hi_m, lo_m);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    old_lo = lo_m;
    @(negedge clk);
    md_if.md_op = 3'd4; md_if.md_a = 32'hDEAD_BEEF; md_if.md_start = 1'b1;
    @(negedge clk);
    checks++;
    if ({md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done} !== {32'hDEAD_BEEF, old_lo, 2'b00}) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b, expected hi=deadbeef lo=%h busy=0 done=0",
               md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, old_lo);
    end
    md_if.md_op = 3'd5; md_if.md_a = 32'h1234_5678;
    @(negedge clk);
    md_if.md_start = 1'b0;
    checks++;
    if ({md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done} !== {32'hDEAD_BEEF, 32'h1234_5678, 2'b00}) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b, expected hi=deadbeef lo=12345678 busy=0 done=0",
               md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done);
    end
    hi_m = 32'hDEAD_BEEF; lo_m = 32'h1234_5678;
    md_if.md_op = 3'd4; md_if.md_a = 32'hCAFE_F00D; md_if.md_start = 1'b1; md_if.md_flush = 1'b1;
    @(negedge clk);
    md_if.md_start = 1'b0; md_if.md_flush = 1'b0;
    checks++;
    if (md_if.hi !== hi_m) begin
      errors++;
      $display("FAIL mthi_flush: got hi=%h, expected %h", md_if.hi, hi_m);
    end
    md_if.md_op = 3'd6; md_if.md_a = 32'h55; md_if.md_start = 1'b1;
    @(negedge clk);
    md_if.md_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done} !== {hi_m, lo_m, 2'b00}) begin
      errors++;
      $display("FAIL undefined_op: got hi=%h lo=%h busy=%b done=%b, expected hi=%h lo=%h busy=0 done=0",
               md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] ohi, olo; logic odz, b1; exp_t e;
    @(negedge clk);
    md_if.md_op = 3'd2; md_if.md_a = 32'hFFFF_FF9C; md_if.md_b = 32'd3; md_if.md_start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      md_if.md_start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, md_if.md_div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero",
               md_if.hi, md_if.lo, md_if.md_busy, md_if.md_done, md_if.md_div_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    sb_q.delete();
    run_op(3'd1, 32'd3, 32'd5, 1'b0, cyc, ohi, olo, odz, b1);
    e = sb_q.pop_front();
    checks++;
    if ({ohi, olo, cyc} !== {e.hi, e.lo, e.lat} || olo !== 32'd15) begin
      errors++;
      $display("FAIL multu_after_reset: got hi=%h lo=%h cyc=%0d, expected hi=%h lo=%h cyc=%0d",
               ohi, olo, cyc, e.hi, e.lo, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[3] = '{3'd1, 3'd2, 3'd0};
    logic [31:0] as[3]  = '{32'h0001_0000, 32'hFFFF_FF9C, 32'h7FFF_FFFF};
    logic [31:0] bs[3]  = '{32'h0001_0001, 32'd7, 32'hFFFF_FFFF};
    int cyc; logic [31:0] ohi, olo; logic odz, b1; exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], (i != 0), cyc, ohi, olo, odz, b1);
      e = sb_q.pop_front();
      checks++;
      if ({ohi, olo, cyc} !== {e.hi, e.lo, e.lat}) begin
        errors++;
        $display("FAIL b2b[%0d]: got hi=%h lo=%h cyc=%0d, expected hi=%h lo=%h cyc=%0d",
                 i, ohi, olo, cyc, e.hi, e.lo, e.lat);
      end
    end
    @(negedge clk);
    checks++;
    if (md_if.md_done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b, expected 0", md_if.md_done);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_flush();
    test_mthi_mtlo();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
